// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder: 1-cycle hit latency, line refill over a req/ack port.
// Optional hit/miss statistics counters are compiled in when ICACHE_STATS_EN is defined.
module icache_responder #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_en,
    output logic [31:0] fetch_inst,
    output logic        fetch_valid,
    output logic        fetch_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
    localparam int unsigned TAG_BITS = 32 - 2 - OFF_BITS - INDEX_BITS;
    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

    typedef enum logic {LOOKUP, REFILL} state_t;
    state_t state_q, state_d;

    logic [31:0]           data_q [LINES*LINE_WORDS];
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [LINES-1:0]      valid_q;
    logic [31:0]           fetch_inst_q;
    logic                  fetch_valid_q;
    logic                  mem_req_q;
    logic [31:0]           mem_addr_q;
    logic [OFF_BITS-1:0]   cnt_q;
    logic                  flush_pend_q;

    logic [OFF_BITS-1:0]   lk_off;
    logic [INDEX_BITS-1:0] lk_idx, rf_idx;
    logic [TAG_BITS-1:0]   lk_tag, rf_tag;
    logic                  hit, accept, miss_start, word_ack, last_ack, drop_line;

    assign lk_off = fetch_addr[2 +: OFF_BITS];
    assign lk_idx = fetch_addr[2+OFF_BITS +: INDEX_BITS];
    assign lk_tag = fetch_addr[31 -: TAG_BITS];
    // Refill target comes from the registered line address; offset increments never touch index/tag.
    assign rf_idx = mem_addr_q[2+OFF_BITS +: INDEX_BITS];
    assign rf_tag = mem_addr_q[31 -: TAG_BITS];

    assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign accept     = fetch_en && !fetch_stall;
    assign miss_start = (state_q == LOOKUP) && fetch_en && (!hit || flush);
    assign word_ack   = (state_q == REFILL) && mem_req_q && mem_ack;
    assign last_ack   = word_ack && (cnt_q == LAST_WORD);
    assign drop_line  = flush_pend_q || flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LOOKUP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOOKUP:  if (miss_start) state_d = REFILL;
            REFILL:  if (last_ack)   state_d = LOOKUP;
            default: state_d = LOOKUP;
        endcase
    end

    // A flush during lookup forces a miss so the stale line is never returned.
    always_comb begin
        fetch_stall = fetch_en && ((state_q != LOOKUP) || !hit || flush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_inst_q  <= '0;
            fetch_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            cnt_q         <= '0;
            flush_pend_q  <= 1'b0;
            valid_q       <= '0;
        end else begin
            fetch_valid_q <= accept;
            if (accept) fetch_inst_q <= data_q[{lk_idx, lk_off}];
            if (miss_start) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= {fetch_addr[31:2+OFF_BITS], {(2+OFF_BITS){1'b0}}};
                cnt_q      <= '0;
            end
            if ((state_q == LOOKUP) && flush) valid_q <= '0;
            if ((state_q == REFILL) && flush) flush_pend_q <= 1'b1;
            if (word_ack) begin
                if (cnt_q == LAST_WORD) begin
                    mem_req_q    <= 1'b0;
                    flush_pend_q <= 1'b0;
                    if (drop_line) valid_q <= '0;
                    else           valid_q[rf_idx] <= 1'b1;
                end else begin
                    cnt_q      <= cnt_q + 1'b1;
                    mem_addr_q <= mem_addr_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_ack) data_q[{rf_idx, cnt_q}] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (last_ack && !drop_line) tag_q[rf_idx] <= rf_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (accept)     hit_count  <= hit_count + 32'd1;
            if (miss_start) miss_count <= miss_count + 32'd1;
        end
    end
`endif

    assign fetch_inst  = fetch_inst_q;
    assign fetch_valid = fetch_valid_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: behavioural backing memory with configurable ack delay
// and a queue of expected instruction words checked as responses appear.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_en;
    logic [31:0] fetch_inst;
    logic        fetch_valid;
    logic        fetch_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] addr_log[$];
    int          mem_delay = 0;
    int          req_cycles = 0;
    int          stab_viol = 0;

    always #5 clk = ~clk;

    icache_responder #(.INDEX_BITS(6), .LINE_WORDS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_addr  (fetch_addr),
        .fetch_en    (fetch_en),
        .fetch_inst  (fetch_inst),
        .fetch_valid (fetch_valid),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
    endfunction

    // Backing memory: acks each word after mem_delay idle cycles, logs acked addresses.
    initial begin
        int          wait_cnt;
        logic        prev_waiting;
        logic [31:0] prev_addr;
        wait_cnt = 0; prev_waiting = 1'b0; prev_addr = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (prev_waiting && (!mem_req || mem_addr !== prev_addr)) stab_viol++;
            prev_waiting = 1'b0;
            if (mem_req) begin
                req_cycles++;
                if (wait_cnt >= mem_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    addr_log.push_back(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    mem_ack      = 1'b0;
                    mem_rdata    = 32'hDEAD_BEEF;
                    wait_cnt++;
                    prev_waiting = 1'b1;
                    prev_addr    = mem_addr;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Called at a negedge; drives a fetch, counts stalled cycles, returns at the negedge
    // where the response to the accepted request is visible.
    task automatic fetch(input logic [31:0] a, output int stalls);
        fetch_en = 1'b1; fetch_addr = a; stalls = 0;
        #1;
        while (fetch_stall && stalls < 400) begin
            @(negedge clk); stalls++; #1;
        end
        exp_q.push_back(mem_word({a[31:2], 2'b00}));
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; fetch_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", fetch_valid); else passed++;
        checks++; if (fetch_inst !== 32'h0) $display("FAIL reset_inst: got %0h expected 0", fetch_inst); else passed++;
        checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %0h expected 0", mem_req); else passed++;
        checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %0h expected 0", mem_addr); else passed++;
        checks++; if (fetch_stall !== 1'b0) $display("FAIL reset_stall: got %0h expected 0", fetch_stall); else passed++;
        @(negedge clk);
    endtask

    task automatic test_refill(input string name, input logic [31:0] a, input int delay);
        int          s;
        logic [31:0] got, exp;
        mem_delay = delay;
        addr_log.delete();
        stab_viol = 0;
        fetch(a, s);
        checks++; if (s != 1 + 4 * (delay + 1)) $display("FAIL %s_stalls: got %0d expected %0d", name, s, 1 + 4 * (delay + 1)); else passed++;
        for (int i = 0; i < 4; i++) begin
            got = (i < addr_log.size()) ? addr_log[i] : 32'hXXXX_XXXX;
            exp = {a[31:4], 4'h0} + 32'(4 * i);
            checks++; if (got !== exp) $display("FAIL %s_memaddr%0d: got %0h expected %0h", name, i, got, exp); else passed++;
        end
        checks++; if (stab_viol != 0) $display("FAIL %s_req_stable: got %0d violations expected 0", name, stab_viol); else passed++;
        checks++; if (fetch_valid !== 1'b1) $display("FAIL %s_valid: got %0h expected 1", name, fetch_valid); else passed++;
        exp = exp_q.pop_front();
        checks++; if (fetch_inst !== exp) $display("FAIL %s_inst: got %0h expected %0h", name, fetch_inst, exp); else passed++;
        mem_delay = 0;
    endtask

    task automatic test_hit_stream();
        int          s;
        logic [31:0] exp;
        req_cycles = 0;
        for (int i = 1; i < 4; i++) begin
            fetch(32'(4 * i), s);
            checks++; if (s != 0) $display("FAIL hit%0d_stalls: got %0d expected 0", i, s); else passed++;
            checks++; if (fetch_valid !== 1'b1) $display("FAIL hit%0d_valid: got %0h expected 1", i, fetch_valid); else passed++;
            exp = exp_q.pop_front();
            checks++; if (fetch_inst !== exp) $display("FAIL hit%0d_inst: got %0h expected %0h", i, fetch_inst, exp); else passed++;
        end
        checks++; if (req_cycles != 0) $display("FAIL hit_no_memreq: got %0d req cycles expected 0", req_cycles); else passed++;
`ifdef ICACHE_STATS_EN
        checks++; if (hit_count !== 32'd4) $display("FAIL stats_hits: got %0d expected 4", hit_count); else passed++;
        checks++; if (miss_count !== 32'd1) $display("FAIL stats_misses: got %0d expected 1", miss_count); else passed++;
`endif
    endtask

    task automatic test_flush();
        int          s;
        logic [31:0] exp;
        fetch(32'h4, s);
        checks++; if (s != 0) $display("FAIL flush_prehit_stalls: got %0d expected 0", s); else passed++;
        void'(exp_q.pop_front());
        // Flush in LOOKUP on a would-be hit.
        fetch_en = 1'b1; fetch_addr = 32'h4; flush = 1'b1; s = 0;
        #1;
        checks++; if (fetch_stall !== 1'b1) $display("FAIL flush_lookup_stall: got %0h expected 1", fetch_stall); else passed++;
        while (fetch_stall && s < 400) begin
            @(negedge clk); s++; flush = 1'b0; #1;
        end
        exp_q.push_back(mem_word(32'h4));
        @(negedge clk); fetch_en = 1'b0;
        checks++; if (s != 5) $display("FAIL flush_lookup_stalls: got %0d expected 5", s); else passed++;
        exp = exp_q.pop_front();
        checks++; if (fetch_inst !== exp) $display("FAIL flush_lookup_inst: got %0h expected %0h", fetch_inst, exp); else passed++;
        // Flush during REFILL coinciding with word 2: line dropped, so the fetch refills twice.
        fetch_en = 1'b1; fetch_addr = 32'h2040; s = 0;
        #1;
        while (fetch_stall && s < 400) begin
            @(negedge clk); s++; flush = (s == 3); #1;
        end
        flush = 1'b0;
        exp_q.push_back(mem_word(32'h2040));
        @(negedge clk); fetch_en = 1'b0;
        checks++; if (s != 10) $display("FAIL flush_refill_stalls: got %0d expected 10", s); else passed++;
        checks++; if (fetch_valid !== 1'b1) $display("FAIL flush_refill_valid: got %0h expected 1", fetch_valid); else passed++;
        exp = exp_q.pop_front();
        checks++; if (fetch_inst !== exp) $display("FAIL flush_refill_inst: got %0h expected %0h", fetch_inst, exp); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_refill();
        int          s;
        logic [31:0] exp;
        fetch_en = 1'b1; fetch_addr = 32'h3000;
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL rst_mid_req: got %0h expected 0", mem_req); else passed++;
        checks++; if (fetch_valid !== 1'b0) $display("FAIL rst_mid_valid: got %0h expected 0", fetch_valid); else passed++;
`ifdef ICACHE_STATS_EN
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) $display("FAIL rst_mid_stats: got %0d/%0d expected 0/0", hit_count, miss_count); else passed++;
`endif
        @(negedge clk);
        reset = 1'b0;
        fetch(32'h0, s);
        checks++; if (s != 5) $display("FAIL rst_after_miss_stalls: got %0d expected 5", s); else passed++;
        exp = exp_q.pop_front();
        checks++; if (fetch_inst !== exp) $display("FAIL rst_after_inst: got %0h expected %0h", fetch_inst, exp); else passed++;
`ifdef ICACHE_STATS_EN
        checks++; if (miss_count !== 32'd1) $display("FAIL rst_after_misses: got %0d expected 1", miss_count); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_refill("cold", 32'h0, 0);
        test_hit_stream();
        test_refill("conflict", 32'h400, 0);
        test_refill("conflict_back", 32'h0, 0);
        test_refill("slow", 32'h1010, 3);
        test_flush();
        test_reset_mid_refill();
        checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
